// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock-enable divider bank and reset sequencer.
package clk_rst_pkg;

    typedef enum logic {
        RS_ASSERT = 1'b0,
        RS_RUN    = 1'b1
    } rst_state_t;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // Hold-counter width; a single bit is enough when HOLD is 1.
    function automatic int unsigned hold_width(input int unsigned hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: square-wave toggle output or one-cycle strobe, with a
// divisor shadow that is only reloaded at a wrap so periods never get cut short.
module clk_div_chan
    import clk_rst_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          mode,
    input  logic [CW-1:0] div,
    output logic          out,
    output logic          tick
);

    logic [CW-1:0] ctr_q, ctr_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          primed_q, primed_d;
    logic          out_q, out_d;
    logic          tick_q, tick_d;

    // Next-state: clear has priority, then priming, then count/wrap.
    always_comb begin
        ctr_d    = ctr_q;
        shadow_d = shadow_q;
        primed_d = primed_q;
        out_d    = out_q;
        tick_d   = 1'b0;

        if (clr) begin
            ctr_d    = '0;
            primed_d = 1'b0;
            out_d    = 1'b0;
        end else begin
            if (en) begin
                if (!primed_q) begin
                    shadow_d = div;
                    ctr_d    = '0;
                    primed_d = 1'b1;
                end else if (ctr_q == shadow_q) begin
                    ctr_d    = '0;
                    shadow_d = div;
                    if (mode == MODE_TOGGLE) begin
                        out_d = ~out_q;
                    end else begin
                        tick_d = 1'b1;
                    end
                end else begin
                    ctr_d = ctr_q + CW'(1);
                end
            end
            // Pulse mode keeps the square-wave output parked low.
            if (mode == MODE_PULSE) begin
                out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctr_q    <= '0;
            shadow_q <= '0;
            primed_q <= 1'b0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            shadow_q <= shadow_d;
            primed_q <= primed_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign out  = out_q;
    assign tick = tick_q;

endmodule

// File: rtl/clk_rst_gen.sv
// Divider bank plus power-on / manual-button reset sequencer for the board wrapper;
// sys_reset also synchronously clears every divider channel.
module clk_rst_gen
    import clk_rst_pkg::*;
#(
    parameter int unsigned NCH  = 2,
    parameter int unsigned CW   = 16,
    parameter int unsigned HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              manual,
    input  logic [NCH*CW-1:0] div,
    input  logic [NCH-1:0]    mode,
    input  logic [NCH-1:0]    en,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    tick,
    output logic              sys_reset,
    output logic              rst_done
);

    localparam int unsigned HW = hold_width(HOLD);

    logic          sync1_q;
    logic          manual_s_q;
    rst_state_t    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          sys_reset_q, sys_reset_d;
    logic          rst_done_q, rst_done_d;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            manual_s_q <= 1'b0;
        end else begin
            sync1_q    <= manual;
            manual_s_q <= sync1_q;
        end
    end

    // Sequencer: any active button press restarts the hold count from zero.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RS_ASSERT: begin
                if (manual_s_q) begin
                    hold_d = '0;
                end else if (hold_q == HW'(HOLD - 1)) begin
                    state_d = RS_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            RS_RUN: begin
                if (manual_s_q) begin
                    state_d = RS_ASSERT;
                    hold_d  = '0;
                end
            end
        endcase
        sys_reset_d = (state_d == RS_ASSERT);
        rst_done_d  = (state_q == RS_ASSERT) && (state_d == RS_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RS_ASSERT;
            hold_q      <= '0;
            sys_reset_q <= 1'b1;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sys_reset_q <= sys_reset_d;
            rst_done_q  <= rst_done_d;
        end
    end

    assign sys_reset = sys_reset_q;
    assign rst_done  = rst_done_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .CW(CW)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .clr  (sys_reset_q),
            .en   (en[i]),
            .mode (mode[i]),
            .div  (div[i*CW +: CW]),
            .out  (out[i]),
            .tick (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: directed literal scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_clk_rst_gen;

    localparam int unsigned NCH  = 2;
    localparam int unsigned CW   = 16;
    localparam int unsigned HOLD = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              manual;
    logic [NCH*CW-1:0] div;
    logic [NCH-1:0]    mode;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    out;
    logic [NCH-1:0]    tick;
    logic              sys_reset;
    logic              rst_done;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    clk_rst_gen #(.NCH(NCH), .CW(CW), .HOLD(HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .manual   (manual),
        .div      (div),
        .mode     (mode),
        .en       (en),
        .out      (out),
        .tick     (tick),
        .sys_reset(sys_reset),
        .rst_done (rst_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: reset is "asserted until HOLD quiet edges have elapsed".
    bit ms_pipe [2];
    int quiet;
    bit m_sys, m_done;
    int m_ctr [NCH];
    int m_shd [NCH];
    bit m_prim[NCH];
    logic [NCH-1:0] m_out, m_tick;

    always @(posedge clk or posedge reset) begin
        bit clr;
        if (reset) begin
            ms_pipe[0] = 1'b0; ms_pipe[1] = 1'b0;
            quiet = 0; m_sys = 1'b1; m_done = 1'b0;
            m_out = '0; m_tick = '0;
            for (int i = 0; i < NCH; i++) begin
                m_ctr[i] = 0; m_shd[i] = 0; m_prim[i] = 1'b0;
            end
        end else begin
            clr = m_sys;
            m_done = 1'b0;
            if (ms_pipe[1]) begin
                quiet = 0;
                m_sys = 1'b1;
            end else if (m_sys) begin
                quiet++;
                if (quiet >= int'(HOLD)) begin
                    m_sys  = 1'b0;
                    m_done = 1'b1;
                end
            end
            ms_pipe[1] = ms_pipe[0];
            ms_pipe[0] = manual;
            for (int i = 0; i < NCH; i++) begin
                m_tick[i] = 1'b0;
                if (clr) begin
                    m_ctr[i] = 0; m_prim[i] = 1'b0; m_out[i] = 1'b0;
                end else begin
                    if (en[i]) begin
                        if (!m_prim[i]) begin
                            m_shd[i] = int'(div[i*CW +: CW]);
                            m_ctr[i] = 0;
                            m_prim[i] = 1'b1;
                        end else if (m_ctr[i] == m_shd[i]) begin
                            m_ctr[i] = 0;
                            m_shd[i] = int'(div[i*CW +: CW]);
                            if (mode[i]) m_tick[i] = 1'b1;
                            else         m_out[i]  = ~m_out[i];
                        end else begin
                            m_ctr[i]++;
                        end
                    end
                    if (mode[i]) m_out[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_sys_reset", sys_reset, m_sys);
            chk("model_rst_done", rst_done, m_done);
            chk("model_out", out, m_out);
            chk("model_tick", tick, m_tick);
        end
    end

    initial begin
        int mpulse;
        logic [CW-1:0] rd;
        reset  = 1'b1;
        manual = 1'b0;
        en     = 2'b11;
        mode   = 2'b10;
        div    = {16'd4, 16'd2};
        repeat (3) @(negedge clk);
        chk("reset_sys_reset", sys_reset, 1);
        chk("reset_rst_done", rst_done, 0);
        chk("reset_out", out, 0);
        chk("reset_tick", tick, 0);
        cmp_on = 1'b1;
        #1 reset = 1'b0;

        // Power-on release, toggle ch0 div=2, pulse ch1 div=4.
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            chk("por_sys_reset", sys_reset, (k < 4) ? 1 : 0);
            chk("por_rst_done", rst_done, (k == 4) ? 1 : 0);
            chk("por_out0", out[0], (k >= 8 && ((k - 8) / 3) % 2 == 0) ? 1 : 0);
            chk("por_tick1", tick[1], (k >= 10 && (k - 10) % 5 == 0) ? 1 : 0);
        end

        // Switching a high toggle output into pulse mode parks it low.
        chk("pre_mode_out0", out[0], 1);
        #1 mode[0] = 1'b1;
        @(negedge clk);
        chk("mode_switch_out0", out[0], 0);
        #1 mode[0] = 1'b0;
        manual = 1'b1;

        // Manual press for 10 cycles, then a divisor change mid-period on ch0.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            chk("man_sys_reset", sys_reset, (k >= 3 && k < 16) ? 1 : 0);
            chk("man_rst_done", rst_done, (k == 16) ? 1 : 0);
            if (k >= 4) begin
                chk("man_out0", out[0],
                    ((k >= 20 && k <= 22) || (k >= 29 && k <= 34)) ? 1 : 0);
                chk("man_tick1", tick[1], (k >= 22 && (k - 22) % 5 == 0) ? 1 : 0);
            end
            if (k == 10) #1 manual = 1'b0;
            if (k == 21) #1 div[CW-1:0] = 16'd5;
        end

        // Randomized traffic; the per-cycle compare process does the checking.
        mpulse = 0;
        for (int s = 0; s < 4000; s++) begin
            @(negedge clk);
            #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 799) == 0) reset = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    rd = CW'($urandom_range(0, 6));
                    div[i*CW +: CW] = rd;
                end
                if ($urandom_range(0, 24) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 39) == 0) mode[i] = ~mode[i];
            end
            if (mpulse > 0) begin
                mpulse--;
                if (mpulse == 0) manual = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                manual = 1'b1;
                mpulse = int'($urandom_range(1, 12));
            end
        end
        manual = 1'b0;
        en = '1;
        repeat (30) @(negedge clk);

        // Asynchronous reset with no clock edge in between.
        #1 reset = 1'b1;
        #1;
        chk("async_sys_reset", sys_reset, 1);
        chk("async_rst_done", rst_done, 0);
        chk("async_out", out, 0);
        chk("async_tick", tick, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
